hpi_access_ctrl: RTL
====================

HPI_ACCESS_CTRL -- requirements
Module: hpi_access_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, HPI data width.
REQ-002 SHALL have parameter ADDR_W, default 2, HPI register address width.
REQ-003 SHALL have parameters SETUP_CYC, STROBE_CYC and HOLD_CYC, defaults 1, 2 and 1, phase lengths in clocks, each at least 1.
REQ-004 SHALL have parameter WBUF_DEPTH, default 4, posted-write buffer entries, a power of 2 and at least 2.
REQ-005 SHALL have parameter RST_CYC, default 16, chip-reset pulse length in clocks.
REQ-006 SHALL have ports:
  clk  in  1  sole clock;
  reset  in  1  synchronous, active-high;
  avs_address  in  ADDR_W  Avalon slave address;
  avs_read  in  1  read request;
  avs_write  in  1  write request;
  avs_writedata  in  DATA_W  write data;
  avs_readdata  out  DATA_W  read data;
  avs_waitrequest  out  1  stall;
  hpi_rst_req  in  1  chip-reset request pulse;
  otg_hpi_address  out  ADDR_W  HPI address;
  otg_hpi_data_in  in  DATA_W  HPI read data;
  otg_hpi_data_out  out  DATA_W  HPI write data;
  otg_hpi_data_oe  out  1  data drive enable;
  otg_hpi_r  out  1  read strobe, active-low;
  otg_hpi_w  out  1  write strobe, active-low;
  otg_hpi_cs  out  1  chip select, active-low;
  otg_hpi_reset  out  1  chip reset, active-low;
  wbuf_count  out  clog2(WBUF_DEPTH)+1  buffered writes;
  busy  out  1  FSM not IDLE or buffer non-empty.

Function
REQ-007 SHALL implement FSM states IDLE, SETUP, STROBE, HOLD, RST; every HPI access SHALL traverse SETUP, then STROBE, then HOLD, then IDLE.
REQ-008 SHALL apply this IDLE priority: pending reset request, then buffer head write, then read.
REQ-009 SHALL accept an Avalon write with waitrequest=0 in the same cycle when the buffer is not full; when the buffer is full, SHALL hold waitrequest=1 and accept nothing.
REQ-010 SHALL enqueue {address, data} per accepted write.
REQ-011 SHALL hold a read (waitrequest=1) until the buffer drains, preserving write-before-read order.
REQ-012 SHALL drive address and cs=0 during SETUP, STROBE and HOLD.
REQ-013 SHALL drive r=0 or w=0 only during STROBE; r and w SHALL never be low simultaneously.
REQ-014 For writes, SHALL hold data_oe=1 and data_out stable from SETUP through HOLD.
REQ-015 For reads, SHALL hold data_oe=0, register data_in on the last STROBE clock, and present it on avs_readdata.
REQ-016 SHALL hold read waitrequest high for exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles from the first avs_read cycle when the buffer is empty and the FSM is in IDLE.
REQ-017 SHALL drive waitrequest=0 with valid readdata in the last HOLD cycle.
REQ-018 SHALL hold avs_readdata until the next read completes.
REQ-019 SHALL keep cs=1 for at least one IDLE cycle between consecutive accesses.
REQ-020 SHALL latch hpi_rst_req as pending; an in-flight access SHALL complete first.
REQ-021 In RST, SHALL drive otg_hpi_reset=0 for exactly RST_CYC cycles, clear the pending flag, and stall Avalon reads.
REQ-022 In RST, SHALL retain buffered writes, which resume after RST.
REQ-023 On a simultaneous avs_read and avs_write, SHALL treat the request as a read and ignore the write.
REQ-024 When the buffer is full and the head write is dequeued in the same cycle as a new write, SHALL accept the new write and keep count unchanged.

Reset
REQ-025 On reset=1 at a clk edge, SHALL enter IDLE, empty the buffer, and clear the pending reset flag.
REQ-026 During reset, SHALL drive cs=r=w=1, otg_hpi_reset=1, data_oe=0, address=0, data_out=0, readdata=0, waitrequest=0, wbuf_count=0, busy=0.
REQ-027 On reset mid-access, SHALL abort the access immediately without completing the strobe.

Structure
REQ-028 SHALL import package hpi_pkg, which holds the FSM state enum and the default timing and depth constants.
REQ-029 SHALL implement the posted-write buffer as sub-module hpi_wbuf, a synchronous FIFO with push/pop/full/empty/count; all other logic SHALL remain in hpi_access_ctrl.

Verification
REQ-030 Read, defaults, empty buffer, addr=2, data_in=0xBEEF: waitrequest high 4 cycles, r=0 for 2 cycles, readdata=0xBEEF in cycle 5.
REQ-031 Five back-to-back writes (0x0001..0x0005), depth 4: first four accepted with zero wait; fifth stalls until the first dequeue; HPI shows five w pulses in order with cs=1 gaps.
REQ-032 Write 0x1234 to addr 1, then immediate read of addr 1: the HPI write strobe precedes the read strobe; the read returns data_in.
REQ-033 hpi_rst_req during a write STROBE: the write completes, then otg_hpi_reset=0 for exactly 16 cycles, then the queued access proceeds.
REQ-034 reset asserted in STROBE with 3 buffered writes: next cycle cs=r=w=1, wbuf_count=0, busy=0.
REQ-035 SETUP_CYC=2, STROBE_CYC=3, HOLD_CYC=2 read: waitrequest high for exactly 7 cycles.

Source files
------------

// File: rtl/hpi_pkg.sv
// Shared definitions for the HPI access controller.
// FSM state encoding plus default timing and buffer sizing.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RST
  } hpi_state_e;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 2;
  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 2;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_WBUF_DEPTH = 4;
  localparam int DEF_RST_CYC    = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hpi_wbuf.sv
// Posted-write buffer: synchronous FIFO of {address, data} entries.
// A push while full is taken only when a pop happens in the same cycle.
module hpi_wbuf
  import hpi_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_WBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, payload only so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/hpi_access_ctrl.sv
// Avalon-slave to HPI bridge with posted writes and chip-reset sequencing.
// Every access runs SETUP -> STROBE -> HOLD -> IDLE.
module hpi_access_ctrl
  import hpi_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int WBUF_DEPTH = DEF_WBUF_DEPTH,
  parameter int RST_CYC    = DEF_RST_CYC
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           avs_address,
  input  logic                        avs_read,
  input  logic                        avs_write,
  input  logic [DATA_W-1:0]           avs_writedata,
  output logic [DATA_W-1:0]           avs_readdata,
  output logic                        avs_waitrequest,
  input  logic                        hpi_rst_req,
  output logic [ADDR_W-1:0]           otg_hpi_address,
  input  logic [DATA_W-1:0]           otg_hpi_data_in,
  output logic [DATA_W-1:0]           otg_hpi_data_out,
  output logic                        otg_hpi_data_oe,
  output logic                        otg_hpi_r,
  output logic                        otg_hpi_w,
  output logic                        otg_hpi_cs,
  output logic                        otg_hpi_reset,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic                        busy
);

  localparam int CNT_MAX = max_int(max_int(SETUP_CYC, STROBE_CYC),
                                   max_int(HOLD_CYC, RST_CYC));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CW      = $clog2(WBUF_DEPTH) + 1;
  localparam int EW      = ADDR_W + DATA_W;

  hpi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc_wr_q, acc_wr_d;
  logic [ADDR_W-1:0] acc_addr_q, acc_addr_d;
  logic [DATA_W-1:0] acc_data_q, acc_data_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pend_q, pend_d;

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;

  logic              cnt_last;
  logic              wr_req;
  logic              push_ok;
  logic              rd_done;
  logic              act;

  hpi_wbuf #(
    .WIDTH (EW),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({avs_address, avs_writedata}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign cnt_last = (cnt_q == '0);

  // A read in flight wins over any write presented alongside it
  assign wr_req  = avs_write && !avs_read;
  assign push_ok = !full || pop;
  assign push    = wr_req && push_ok && !reset;
  assign rd_done = (state_q == ST_HOLD) && cnt_last && !acc_wr_q;

  // Next-state, phase timing and head dequeue
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_wr_d   = acc_wr_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    rdata_d    = rdata_q;
    pop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_RST;
          cnt_d   = CNT_W'(RST_CYC - 1);
        end else if (!empty) begin
          state_d    = ST_SETUP;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
          acc_wr_d   = 1'b1;
          acc_addr_d = head[EW-1:DATA_W];
          acc_data_d = head[DATA_W-1:0];
        end else if (avs_read) begin
          state_d    = ST_SETUP;
          cnt_d      = CNT_W'(SETUP_CYC - 1);
          acc_wr_d   = 1'b0;
          acc_addr_d = avs_address;
          acc_data_d = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_last) begin
          state_d = ST_STROBE;
          cnt_d   = CNT_W'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_last) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_W'(HOLD_CYC - 1);
          if (!acc_wr_q) rdata_d = otg_hpi_data_in;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_last) begin
          state_d = ST_IDLE;
          pop     = acc_wr_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RST: begin
        if (cnt_last) state_d = ST_IDLE;
        else          cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new request re-arms the flag even while entering RST
  always_comb begin
    pend_d = hpi_rst_req || (pend_q && !((state_q == ST_IDLE) && pend_q));
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_wr_q   <= 1'b0;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      rdata_q    <= '0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_wr_q   <= acc_wr_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      rdata_q    <= rdata_d;
      pend_q     <= pend_d;
    end
  end

  // Bus outputs; reset forces the idle pattern and aborts any strobe
  always_comb begin
    act = !reset && ((state_q == ST_SETUP) ||
                     (state_q == ST_STROBE) ||
                     (state_q == ST_HOLD));
    otg_hpi_cs       = !act;
    otg_hpi_address  = act ? acc_addr_q : '0;
    otg_hpi_data_oe  = act && acc_wr_q;
    otg_hpi_data_out = (act && acc_wr_q) ? acc_data_q : '0;
    otg_hpi_w        = !(act && acc_wr_q && (state_q == ST_STROBE));
    otg_hpi_r        = !(act && !acc_wr_q && (state_q == ST_STROBE));
    otg_hpi_reset    = !(!reset && (state_q == ST_RST));
    avs_readdata     = reset ? '0 : rdata_q;
    wbuf_count       = reset ? '0 : count;
    busy             = !reset && ((state_q != ST_IDLE) || !empty);
    avs_waitrequest  = 1'b0;
    if (!reset) begin
      if (avs_read)       avs_waitrequest = !rd_done;
      else if (avs_write) avs_waitrequest = !push_ok;
    end
  end

endmodule
